// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, PC-mux selects,
// MIPS ExcCodes and the priority encoder result record.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ENTER   = 2'b01,
        ST_HANDLER = 2'b10,
        ST_RETURN  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        PC_SEQ     = 2'b00,
        PC_HANDLER = 2'b01,
        PC_EPC     = 2'b10
    } pc_sel_t;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef struct packed {
        logic ri;
        logic sys;
        logic bp;
        logic ov;
    } sync_exc_t;

    typedef struct packed {
        logic       hit;
        logic       is_int;
        logic [4:0] code;
        logic [2:0] id;
    } prio_res_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline <-> exception sequencer bundle: exception/interrupt sources in, CP0/PC-mux controls out.
interface exc_ctrl_if #(
    parameter int HW_INT_W = 6
);
    logic                stall;
    logic [31:0]         pc_in;
    logic                exc_ri;
    logic                exc_sys;
    logic                exc_bp;
    logic                exc_ov;
    logic                eret;
    logic [HW_INT_W-1:0] hw_int;
    logic [HW_INT_W-1:0] int_mask;

    logic                exl_set;
    logic                exl_clear;
    logic [31:0]         exc_pc;
    logic                flush;
    logic [1:0]          pc_sel;
    logic [4:0]          exc_code;
    logic [2:0]          int_id;
    logic                exl;
    logic                dbl_fault;

    modport master (
        output stall, pc_in, exc_ri, exc_sys, exc_bp, exc_ov, eret, hw_int, int_mask,
        input  exl_set, exl_clear, exc_pc, flush, pc_sel, exc_code, int_id, exl, dbl_fault
    );

    modport slave (
        input  stall, pc_in, exc_ri, exc_sys, exc_bp, exc_ov, eret, hw_int, int_mask,
        output exl_set, exl_clear, exc_pc, flush, pc_sel, exc_code, int_id, exl, dbl_fault
    );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational priority encoder: RI > SYS > BP > OV > interrupts (lowest index first).
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int NI = 6
) (
    input  logic          i_sync_en,
    input  sync_exc_t     i_exc,
    input  logic [NI-1:0] i_pend,
    output prio_res_t     o_res
);
    always_comb begin
        o_res = '0;
        // Walk from the top so the lowest pending index is the one left standing
        for (int i = NI - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_res.hit    = 1'b1;
                o_res.is_int = 1'b1;
                o_res.code   = EXC_INT;
                o_res.id     = 3'(i);
            end
        end
        if (i_sync_en && (|i_exc)) begin
            o_res.hit    = 1'b1;
            o_res.is_int = 1'b0;
            o_res.code   = i_exc.ri  ? EXC_RI  :
                           i_exc.sys ? EXC_SYS :
                           i_exc.bp  ? EXC_BP  : EXC_OV;
        end
    end
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer upstream of CP0: IDLE -> ENTER -> HANDLER -> RETURN.
// Define EXC_CTRL_TIMER_EN to add a free-running timer as the lowest-priority interrupt.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          HW_INT_W     = 6,
    parameter logic [31:0] TIMER_PERIOD = 32'd1000
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    exc_ctrl_if.slave bus
);
`ifdef EXC_CTRL_TIMER_EN
    localparam int NI = HW_INT_W + 1;
`else
    localparam int NI = HW_INT_W;
`endif

    state_t              r_state, w_nxt;
    pc_sel_t             r_pc_sel, w_pc_sel;
    logic [HW_INT_W-1:0] r_pend;
    logic [NI-1:0]       w_pend_vec, w_clr;
    prio_res_t           w_res;
    sync_exc_t           w_sync;
    logic                w_take;
    logic                w_exl_set, w_exl_clear, w_flush, w_exl;
    logic                r_exl_set, r_exl_clear, r_flush, r_exl, r_dbl;
    logic [31:0]         r_exc_pc;
    logic [4:0]          r_exc_code;
    logic [2:0]          r_int_id;

    assign w_sync = {bus.exc_ri, bus.exc_sys, bus.exc_bp, bus.exc_ov};
    assign w_take = (r_state == ST_IDLE) && w_res.hit;
    assign w_clr  = (w_take && w_res.is_int) ? (NI'(1) << w_res.id) : '0;

    exc_prio_enc #(.NI(NI)) u_prio (
        .i_sync_en (~bus.stall),
        .i_exc     (w_sync),
        .i_pend    (w_pend_vec),
        .o_res     (w_res)
    );

    // A still-asserted line re-latches in the same cycle its bit is taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pend <= '0;
        else          r_pend <= (r_pend & ~w_clr[HW_INT_W-1:0]) | (bus.hw_int & bus.int_mask);
    end

`ifdef EXC_CTRL_TIMER_EN
    logic [31:0] r_tmr;
    logic        r_tmr_pend;
    logic        w_wrap;

    assign w_wrap = (r_tmr == TIMER_PERIOD - 32'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmr      <= '0;
            r_tmr_pend <= 1'b0;
        end else begin
            r_tmr      <= w_wrap ? '0 : r_tmr + 32'd1;
            r_tmr_pend <= (r_tmr_pend & ~w_clr[HW_INT_W]) | w_wrap;
        end
    end

    assign w_pend_vec = {r_tmr_pend, r_pend};
`else
    assign w_pend_vec = r_pend;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_res.hit) w_nxt = ST_ENTER;
            ST_ENTER:   w_nxt = ST_HANDLER;
            ST_HANDLER: if (!bus.stall && bus.eret) w_nxt = ST_RETURN;
            ST_RETURN:  w_nxt = ST_IDLE;
            default:    w_nxt = ST_IDLE;
        endcase
    end

    // Decoded from the next state so every control output comes straight off a flop
    always_comb begin
        w_exl_set   = (w_nxt == ST_ENTER);
        w_exl_clear = (w_nxt == ST_RETURN);
        w_flush     = w_exl_set | w_exl_clear;
        w_exl       = (w_nxt == ST_HANDLER) || (w_nxt == ST_RETURN);
        case (w_nxt)
            ST_ENTER:  w_pc_sel = PC_HANDLER;
            ST_RETURN: w_pc_sel = PC_EPC;
            default:   w_pc_sel = PC_SEQ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exl_set   <= 1'b0;
            r_exl_clear <= 1'b0;
            r_flush     <= 1'b0;
            r_exl       <= 1'b0;
            r_pc_sel    <= PC_SEQ;
            r_dbl       <= 1'b0;
            r_exc_pc    <= '0;
            r_exc_code  <= '0;
            r_int_id    <= '0;
        end else begin
            r_exl_set   <= w_exl_set;
            r_exl_clear <= w_exl_clear;
            r_flush     <= w_flush;
            r_exl       <= w_exl;
            r_pc_sel    <= w_pc_sel;
            if (r_state == ST_HANDLER && !bus.stall && (|w_sync)) r_dbl <= 1'b1;
            if (w_take) begin
                r_exc_pc   <= bus.pc_in;
                r_exc_code <= w_res.code;
                if (w_res.is_int) r_int_id <= w_res.id;
            end
        end
    end

    assign bus.exl_set   = r_exl_set;
    assign bus.exl_clear = r_exl_clear;
    assign bus.flush     = r_flush;
    assign bus.exl       = r_exl;
    assign bus.pc_sel    = r_pc_sel;
    assign bus.dbl_fault = r_dbl;
    assign bus.exc_pc    = r_exc_pc;
    assign bus.exc_code  = r_exc_code;
    assign bus.int_id    = r_int_id;
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer directly upstream of the CP0 block.
- Collects synchronous exception flags from decode/execute, the hardware interrupt lines and eret, then prioritises them.
- Drives CP0's exl-set, exl-clear and faulting-PC inputs, the pipeline flush, and the PC-mux select (normal / handler / EPC).
- Tracks the EXL state locally so interrupts are masked while a handler runs.

Parameters:
- HW_INT_W, 6: number of hardware interrupt lines.
- TIMER_PERIOD, 32'd1000: timer interrupt period in clk cycles (used only with EXC_CTRL_TIMER_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  pipeline stall; sync-exception and eret sampling is suppressed while high.
- pc_in  in  32  PC of the instruction in execute.
- exc_ri  in  1  reserved/illegal instruction.
- exc_sys  in  1  syscall.
- exc_bp  in  1  break.
- exc_ov  in  1  arithmetic overflow.
- eret  in  1  eret executing.
- hw_int  in  HW_INT_W  interrupt request lines, level.
- int_mask  in  HW_INT_W  1 = line enabled.
- exl_set  out  1  to CP0 EXLSet.
- exl_clear  out  1  to CP0 EXLClear.
- exc_pc  out  32  to CP0 PC (EPC source).
- flush  out  1  kill IF/ID/EX contents.
- pc_sel  out  2  00 = sequential, 01 = handler_PC, 10 = EPC.
- exc_code  out  5  MIPS ExcCode of the last taken exception.
- int_id  out  3  index of the last taken interrupt.
- exl  out  1  local EXL copy.
- dbl_fault  out  1  sticky: sync exception seen while exl = 1.

Behaviour:
- Registered outputs, reset values:
  - exl_set, exl_clear, flush, exl, dbl_fault = 0
  - pc_sel = 00, exc_pc = 0, exc_code = 0, int_id = 0
  - FSM = IDLE, pending = 0
- pending[HW_INT_W-1:0]:
  - Each clk, pending |= hw_int & int_mask.
  - The taken bit is cleared on entry.
  - Latched regardless of stall or state.
- FSM states IDLE, ENTER, HANDLER, RETURN.
- IDLE, stall = 0, priority:
  - exc_ri (code 10) > exc_sys (8) > exc_bp (9) > exc_ov (12) > any pending interrupt (code 0; lowest index wins).
  - On a hit: next state ENTER; latch exc_pc = pc_in, exc_code, and int_id (interrupt case only).
- IDLE, stall = 1: sync flags and eret are ignored; an interrupt is still taken if pending != 0.
- IDLE, eret: ignored (no EXL).
- ENTER, exactly 1 cycle: exl_set = 1, flush = 1, pc_sel = 01, exl becomes 1; then HANDLER.
- Latency: event sampled at edge N → exl_set/flush/pc_sel valid during cycle N+1.
- HANDLER:
  - exl = 1; interrupts are latched but not taken.
  - Sync exception with stall = 0: dbl_fault set (sticky until reset), otherwise ignored; EPC is not overwritten.
  - eret with stall = 0 → RETURN.
  - eret and a sync exception in the same cycle: eret wins, dbl_fault is still set.
- RETURN, exactly 1 cycle: exl_clear = 1, flush = 1, pc_sel = 10 (CP0 EPC is still valid this cycle); then IDLE with exl = 0.
- Interrupts pending on return are taken from IDLE in the following cycle.
- Async reset at any point returns all state to reset values immediately; pending is cleared.
- exc_pc, exc_code and int_id hold their values outside ENTER.

Optional Feature:
- Macro: EXC_CTRL_TIMER_EN.
- Defined:
  - A 32-bit free-running counter counts from 0 to TIMER_PERIOD-1, then wraps to 0.
  - On wrap it sets timer_pend.
  - timer_pend is the lowest-priority interrupt, int_id = HW_INT_W, and is cleared when taken.
  - Always enabled (no mask bit).
  - Counter resets to 0.
- Undefined: no counter or timer_pend logic; behaviour is identical to the above minus the timer source.

Decomposition:
- Package exc_pkg:
  - FSM state encoding.
  - pc_sel encodings PC_SEQ / PC_HANDLER / PC_EPC.
  - ExcCode constants EXC_INT = 0, EXC_SYS = 8, EXC_BP = 9, EXC_RI = 10, EXC_OV = 12.
- One sub-module is natural: exc_prio_enc, a combinational priority encoder returning hit, code and int_id from the flags and pending vector.

Test Plan:
- Reset: rst low mid-HANDLER → all outputs 0, FSM IDLE, pending 0 on the same edge (asynchronous).
- Sync exception: pc_in = 32'h40, exc_sys = 1 in IDLE → next cycle exl_set = 1, flush = 1, pc_sel = 01, exc_pc = 32'h40, exc_code = 8; following cycle exl = 1, exl_set = 0.
- Priority: exc_ri = exc_ov = 1, hw_int = 6'b000100 with mask all ones → exc_code = 10; after eret/RETURN, interrupt 2 is taken with exc_code = 0, int_id = 2.
- Masking: hw_int[1] pulses 1 cycle during HANDLER, mask[1] = 1 → not taken; after eret (RETURN: exl_clear = 1, pc_sel = 10) it is taken from IDLE with int_id = 1.
- Double fault: exc_ov in HANDLER → dbl_fault = 1, no exl_set, exc_pc unchanged; stall = 1 with exc_bp in IDLE → no entry.
- EXC_CTRL_TIMER_EN, TIMER_PERIOD = 10, no other sources → first entry after 10 cycles with exc_code = 0, int_id = HW_INT_W.
